// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous
// clock (e.g. a divided 1 Hz tick) in system-clock cycles.
//
// A start request arms the meter. It waits for a synchronized rising edge,
// counts to the next falling edge (high time), and then counts to the next
// rising edge (period). After that it pulses valid. If an expected edge does
// not arrive within TIMEOUT_CYC cycles, the measurement is aborted with a
// timeout pulse.
//
// Optional feature macro: CLKMON_CONTINUOUS_EN
//   When it is defined, the rise that closes a period also opens the next one.
//   A valid is then produced every inclk period until a timeout or reset.
//   When it is not defined, the meter makes one measurement per start.
//
// TIMEOUT_CYC must be smaller than 2**CNT_W.

module clk_period_meter #(
  parameter int CNT_W       = 28,
  parameter int TIMEOUT_CYC = 200000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inclk,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Synchronizer chain plus previous-sample flop.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cur_s;
  logic                   rise_s;
  logic                   fall_s;

  // FSM and datapath state.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0] cnt_inc_s;
  logic             at_limit_s;

  // Bring inclk into the clk domain. All flops reset high, so an idle-high input
  // does not produce a spurious edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{1'b1}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inclk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur_s  = sync_q[SYNC_STAGES-1];
  assign rise_s = cur_s & ~prev_q;
  assign fall_s = ~cur_s & prev_q;

  // Saturating increment. This guards the corner where a fall arrives exactly
  // at the timeout limit and the count steps past it.
  assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
  assign at_limit_s = (cnt_q >= TO_VAL);

  // Next-state and datapath logic. A qualifying edge always takes priority
  // over the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cnt_d    = hi_cnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (rise_s) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ONE;
        end else if (at_limit_s) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_HIGH: begin
        if (fall_s) begin
          state_d  = ST_LOW;
          hi_cnt_d = cnt_q;
          cnt_d    = cnt_inc_s;
        end else if (at_limit_s) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          period_d    = cnt_q;
          high_time_d = hi_cnt_q;
          valid_d     = 1'b1;
`ifdef CLKMON_CONTINUOUS_EN
          state_d     = ST_HIGH;
          cnt_d       = CNT_ONE;
`else
          state_d     = ST_IDLE;
`endif
        end else if (at_limit_s) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      hi_cnt_q    <= CNT_ZERO;
      period_q    <= CNT_ZERO;
      high_time_q <= CNT_ZERO;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign period    = period_q;
  assign high_time = high_time_q;

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures a slow, divided clock or square-wave signal (for example a 1 Hz tick output) in system-clock cycles.
- Reports the period and the high time on request; this is the checking end of the team's clock-divider outputs.
- Used for self-test and bring-up: confirms divided clocks run at the programmed rate and duty before they are consumed downstream.

Parameters:
- CNT_W, 28, width of the cycle counter and of the period/high_time outputs.
- TIMEOUT_CYC, 200000000, cycles without a required edge before the measurement aborts; must be < 2**CNT_W.
- SYNC_STAGES, 2, flops in the inclk synchronizer chain (>= 2).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset; clears all state.
- inclk, input, 1, asynchronous slow clock under measurement.
- start, input, 1, one-cycle request to begin a measurement; ignored unless idle.
- busy, output, 1, high from the cycle after an accepted start until done or timeout.
- valid, output, 1, one-cycle pulse: period/high_time updated.
- timeout, output, 1, one-cycle pulse: measurement aborted.
- period, output, CNT_W, cycles between consecutive detected rising edges.
- high_time, output, CNT_W, cycles from detected rising edge to detected falling edge.

Behaviour:
- Synchronizer: SYNC_STAGES flops plus one "previous" flop, all reset to 1.
  - rise = cur & ~prev; fall = ~cur & prev.
  - Both edges lag inclk by the same latency, so measured intervals are exact to ±1 cycle of inclk sampling.
- Reset values:
  - busy = 0, valid = 0, timeout = 0.
  - period = 0, high_time = 0.
  - cnt = 0, state = IDLE.
- FSM transitions:
  - IDLE: start=1 -> ARM, cnt <= 0.
  - ARM: rise -> HIGH, cnt <= 1. Otherwise cnt <= cnt+1.
  - HIGH: fall -> LOW, high_time <= cnt. Always cnt <= cnt+1.
  - LOW: rise -> high_time already held; period <= cnt, valid <= 1, state <= IDLE. Otherwise cnt <= cnt+1.
- busy = (state != IDLE), registered.
- valid is asserted in the cycle after the rise that closes the period; period and high_time are stable from that cycle on.
- Outputs hold their values until the next valid; they are not cleared by start or timeout.
- Timeout:
  - In ARM, HIGH or LOW, when cnt == TIMEOUT_CYC and no qualifying edge occurs that cycle: timeout <= 1, state <= IDLE.
  - period and high_time are unchanged.
- Boundary conditions:
  - Qualifying edge and cnt == TIMEOUT_CYC in the same cycle: the edge wins, no timeout.
  - start while busy: ignored, with no restart.
  - start in the same cycle as a rise, while in IDLE: that rise is not used; ARM waits for the next rise.
  - fall in ARM and rise in HIGH are ignored. A rise in HIGH cannot occur without a fall; glitches are filtered only by the synchronizer.
  - cnt never wraps, because TIMEOUT_CYC < 2**CNT_W.
- Reset asserted mid-measurement: immediate return to IDLE, all outputs to their reset values.

Optional Feature:
- Macro CLKMON_CONTINUOUS_EN.
- Defined:
  - After a valid, the FSM goes to HIGH with cnt <= 1 instead of IDLE; the closing rise opens the next period.
  - A new valid is produced every inclk period.
  - start is needed only to leave IDLE, which is re-entered only after a timeout or reset.
  - busy stays 1 while running.
- Not defined: one-shot behaviour as specified above.

Test Plan:
- inclk square wave, 10 cycles low / 10 high (period 20), start pulsed once -> after first full cycle: high_time=10, period=20, valid=1 for exactly 1 cycle, busy falls the same cycle valid rises.
- Asymmetric wave, 3 high / 12 low -> high_time=3, period=15; a repeated start gives identical values.
- TIMEOUT_CYC=50, inclk held 0, start -> timeout pulse when cnt==50 (about 51 cycles after start); period and high_time keep their previous values; busy=0 afterwards.
- start pulsed again 5 cycles into a measurement -> no effect; single valid with correct values.
- reset low for 1 cycle while in HIGH -> busy=0, period=0, high_time=0 next cycle; no valid or timeout until a new start.
- With CLKMON_CONTINUOUS_EN, period 20, high 10 -> valid every 20 cycles with period=20 and high_time=10, for at least 4 consecutive pulses.
